// File: rtl/avalon_ram_tester_pkg.sv
// Shared types for the Avalon RAM self-test master: FSM state encoding and
// the helper that tells which passes run on inverted data.
package avalon_ram_tester_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WR0  = 3'd1,
      RD0  = 3'd2,
      WR1  = 3'd3,
      RD1  = 3'd4,
      FIN  = 3'd5
   } state_t;

   // Second write/read pair runs on the complement of the pattern.
   function automatic logic pass_inverts(input state_t s);
      return (s == WR1) || (s == RD1);
   endfunction

endpackage

// File: rtl/avalon_ram_tester_check.sv
// Read-data checker: flags mismatches, keeps a saturating count and captures
// the address/data of the first mismatch since the last clear.
module avalon_ram_tester_check
   import avalon_ram_tester_pkg::*;
#(
   parameter int ADW = 32,
   parameter int AAW = 8,
   parameter int ECW = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           clr,
   input  logic           valid,
   input  logic [AAW-1:0] addr,
   input  logic [ADW-1:0] expected,
   input  logic [ADW-1:0] readdata,
   output logic           error,
   output logic [ECW-1:0] err_cnt,
   output logic [AAW-1:0] err_addr,
   output logic [ADW-1:0] err_data
);

   logic           w_mismatch;
   logic           r_error;
   logic [ECW-1:0] r_err_cnt;
   logic [AAW-1:0] r_err_addr;
   logic [ADW-1:0] r_err_data;

   assign w_mismatch = valid && (readdata != expected);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_error    <= 1'b0;
         r_err_cnt  <= '0;
         r_err_addr <= '0;
         r_err_data <= '0;
      end else if (clr) begin
         r_error    <= 1'b0;
         r_err_cnt  <= '0;
         r_err_addr <= '0;
         r_err_data <= '0;
      end else if (w_mismatch) begin
         r_error <= 1'b1;
         if (r_err_cnt != {ECW{1'b1}})
            r_err_cnt <= r_err_cnt + 1'b1;
         // Only the first failure is kept; later ones just count.
         if (!r_error) begin
            r_err_addr <= addr;
            r_err_data <= readdata;
         end
      end
   end

   assign error    = r_error;
   assign err_cnt  = r_err_cnt;
   assign err_addr = r_err_addr;
   assign err_data = r_err_data;

endmodule

// File: rtl/avalon_ram_tester.sv
// Avalon-MM master running a four-pass pattern test (write, read, write
// inverted, read) over a wrapping word-address window of a RAM slave.
module avalon_ram_tester
   import avalon_ram_tester_pkg::*;
#(
   parameter int ADW = 32,
   parameter int ABW = ADW / 8,
   parameter int AAW = 8,
   parameter int ECW = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [AAW-1:0] base,
   input  logic [AAW:0]   len,
   input  logic [ADW-1:0] seed,
   output logic           busy,
   output logic           done,
   output logic           error,
   output logic [ECW-1:0] err_cnt,
   output logic [AAW-1:0] err_addr,
   output logic [ADW-1:0] err_data,
   output logic           read,
   output logic           write,
   output logic [AAW-1:0] address,
   output logic [ABW-1:0] byteenable,
   output logic [ADW-1:0] writedata,
   input  logic [ADW-1:0] readdata,
   input  logic           waitrequest
);

   state_t         r_state;
   state_t         w_state_nxt;
   logic [AAW-1:0] r_base;
   logic [AAW:0]   r_len;
   logic [ADW-1:0] r_seed;
   logic [AAW-1:0] r_idx;

   logic           w_start_ok;
   logic           w_accept;
   logic           w_last;
   logic [AAW-1:0] w_addr;
   logic [ADW-1:0] w_pattern;
   logic [ADW-1:0] w_data;

   // Valid/ready: a transfer completes on a cycle with (read|write) and no
   // waitrequest; address/writedata come only from registers that change on
   // completion, so they stay stable throughout a stall.
   assign w_start_ok = (r_state == IDLE) && start;
   assign w_accept   = (read || write) && !waitrequest;
   assign w_last     = ({1'b0, r_idx} == (r_len - 1'b1));
   assign w_addr     = r_base + r_idx;
   assign w_pattern  = r_seed + ADW'(r_idx);
   assign w_data     = pass_inverts(r_state) ? ~w_pattern : w_pattern;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_base  <= '0;
         r_len   <= '0;
         r_seed  <= '0;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_start_ok) begin
            r_base <= base;
            r_len  <= len;
            r_seed <= seed;
            r_idx  <= '0;
         end else if (w_accept) begin
            r_idx <= w_last ? '0 : r_idx + 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: if (start) w_state_nxt = (len == '0) ? FIN : WR0;
         WR0:  if (w_accept && w_last) w_state_nxt = RD0;
         RD0:  if (w_accept && w_last) w_state_nxt = WR1;
         WR1:  if (w_accept && w_last) w_state_nxt = RD1;
         RD1:  if (w_accept && w_last) w_state_nxt = FIN;
         FIN:  w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   assign write      = (r_state == WR0) || (r_state == WR1);
   assign read       = (r_state == RD0) || (r_state == RD1);
   assign address    = (read || write) ? w_addr : '0;
   assign writedata  = write ? w_data : '0;
   assign byteenable = {ABW{1'b1}};
   assign busy       = (r_state != IDLE);
   assign done       = (r_state == FIN);

   avalon_ram_tester_check #(
      .ADW(ADW),
      .AAW(AAW),
      .ECW(ECW)
   ) u_check (
      .clk      (clk),
      .rst      (rst),
      .clr      (w_start_ok),
      .valid    (w_accept && read),
      .addr     (w_addr),
      .expected (w_data),
      .readdata (readdata),
      .error    (error),
      .err_cnt  (err_cnt),
      .err_addr (err_addr),
      .err_data (err_data)
   );

endmodule
